// File: rtl/param_icache.sv
// param_icache: direct-mapped, read-only instruction cache with zero-latency hits.
// Defining ICACHE_STATS_EN adds the HIT_CNT / MISS_CNT statistics outputs.
module param_icache #(
    parameter int LINES = 16,
    parameter int WORDS = 4
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                REN,
    input  logic [31:0]         RADDRESS,
    input  logic                FLUSH,
    output logic [31:0]         RDATA,
    output logic                HIT,
    output logic                STALL,
    output logic                MEM_REQ,
    output logic [31:0]         MEM_ADDR,
    input  logic                MEM_ACK,
    input  logic [32*WORDS-1:0] MEM_BLOCK,
`ifdef ICACHE_STATS_EN
    output logic [31:0]         HIT_CNT,
    output logic [31:0]         MISS_CNT,
`endif
    output logic [1:0]          o_dbg_state
);
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);
    localparam int LA_W  = 30 - OFF_W;
    localparam int TAG_W = LA_W - IDX_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_FILL  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [LINES-1:0]    r_valid;
    logic [TAG_W-1:0]    r_tags [LINES];
    logic [32*WORDS-1:0] r_data [LINES];
    logic [32*WORDS-1:0] r_block;
    logic [LA_W-1:0]     r_line_addr;
    logic                r_flush_pend;

    logic [OFF_W-1:0]    w_off;
    logic [IDX_W-1:0]    w_idx;
    logic [TAG_W-1:0]    w_tag;
    logic [IDX_W-1:0]    w_fill_idx;
    logic [TAG_W-1:0]    w_fill_tag;
    logic [31:0]         w_word;
    logic                w_lookup_hit;
    logic                w_flush;
    logic                w_start;
    logic                w_capture;
    logic                w_fill;
    logic                w_clear;
    logic                w_unused_addr;

    assign w_off         = RADDRESS[2 +: OFF_W];
    assign w_idx         = RADDRESS[2+OFF_W +: IDX_W];
    assign w_tag         = RADDRESS[31 -: TAG_W];
    assign w_unused_addr = ^RADDRESS[1:0];
    assign w_fill_idx    = r_line_addr[IDX_W-1:0];
    assign w_fill_tag    = r_line_addr[LA_W-1 -: TAG_W];
    assign w_lookup_hit  = r_valid[w_idx] && (r_tags[w_idx] == w_tag);
    // A flush deferred from FETCH/FILL acts exactly like a live FLUSH on the first IDLE cycle.
    assign w_flush       = FLUSH | r_flush_pend;

    always_comb begin
        w_word = '0;
        for (int i = 0; i < WORDS; i++) begin
            if (w_off == i[OFF_W-1:0]) w_word = r_data[w_idx][32*i +: 32];
        end
    end

    // Memory handshake: MEM_REQ is held with a stable MEM_ADDR for every FETCH cycle;
    // the block transfers on the first edge where MEM_REQ and MEM_ACK are both high.
    always_comb begin
        w_next    = r_state;
        HIT       = 1'b0;
        MEM_REQ   = 1'b0;
        w_start   = 1'b0;
        w_capture = 1'b0;
        w_fill    = 1'b0;
        w_clear   = 1'b0;
        case (r_state)
            S_IDLE: begin
                HIT = REN & w_lookup_hit & ~w_flush;
                if (w_flush) begin
                    w_clear = 1'b1;
                end else if (REN && !w_lookup_hit) begin
                    w_start = 1'b1;
                    w_next  = S_FETCH;
                end
            end
            S_FETCH: begin
                MEM_REQ = 1'b1;
                if (MEM_ACK) begin
                    w_capture = 1'b1;
                    w_next    = S_FILL;
                end
            end
            S_FILL: begin
                w_fill = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign STALL       = (r_state != S_IDLE) | (REN & ~HIT);
    assign RDATA       = HIT ? w_word : 32'd0;
    assign MEM_ADDR    = {r_line_addr, {(OFF_W+2){1'b0}}};
    assign o_dbg_state = r_state;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= S_IDLE;
            r_valid      <= '0;
            r_flush_pend <= 1'b0;
            r_line_addr  <= '0;
        end else begin
            r_state <= w_next;
            if (w_start) r_line_addr <= RADDRESS[31:OFF_W+2];
            if (w_clear) begin
                r_valid <= '0;
            end else if (w_fill) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
            if (r_state != S_IDLE && FLUSH) begin
                r_flush_pend <= 1'b1;
            end else if (w_clear) begin
                r_flush_pend <= 1'b0;
            end
        end
    end

    // Payload storage carries no reset; the valid bits alone decide what is live.
    always_ff @(posedge CLK) begin
        if (w_capture) r_block <= MEM_BLOCK;
        if (w_fill) begin
            r_tags[w_fill_idx] <= w_fill_tag;
            r_data[w_fill_idx] <= r_block;
        end
    end

`ifdef ICACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (HIT)     r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_start) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign HIT_CNT  = r_hit_cnt;
    assign MISS_CNT = r_miss_cnt;
`endif

endmodule

// File: tb/tb_param_icache.sv
// Self-checking bench for param_icache: directed miss/hit/flush/reset scenarios plus random reads
// against a small direct-mapped reference model; read data is checked through an expected queue.
module tb_param_icache;
    localparam int LINES = 16;
    localparam int WORDS = 4;
    localparam int OFF_W = $clog2(WORDS);
    localparam int IDX_W = $clog2(LINES);

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                ren = 1'b0;
    logic [31:0]         raddr = '0;
    logic                flush = 1'b0;
    logic [31:0]         rdata;
    logic                hit;
    logic                stall;
    logic                mem_req;
    logic [31:0]         mem_addr;
    logic                mem_ack = 1'b0;
    logic [32*WORDS-1:0] mem_block = '0;
    logic [1:0]          dbg_state;
`ifdef ICACHE_STATS_EN
    logic [31:0]         hit_cnt;
    logic [31:0]         miss_cnt;
`endif

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];

    logic        m_valid [LINES];
    logic [31:0] m_tag   [LINES];

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1);
    end

    param_icache #(.LINES(LINES), .WORDS(WORDS)) dut (
        .CLK        (clk),
        .RST        (rst),
        .REN        (ren),
        .RADDRESS   (raddr),
        .FLUSH      (flush),
        .RDATA      (rdata),
        .HIT        (hit),
        .STALL      (stall),
        .MEM_REQ    (mem_req),
        .MEM_ADDR   (mem_addr),
        .MEM_ACK    (mem_ack),
        .MEM_BLOCK  (mem_block),
`ifdef ICACHE_STATS_EN
        .HIT_CNT    (hit_cnt),
        .MISS_CNT   (miss_cnt),
`endif
        .o_dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Backing memory content: a bijection of the word address, so every word is distinct.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    function automatic logic [32*WORDS-1:0] mem_blk(input logic [31:0] base);
        logic [32*WORDS-1:0] b;
        b = '0;
        for (int i = 0; i < WORDS; i++) b[32*i +: 32] = mem_word(base + 32'(4*i));
        return b;
    endfunction

    // Drive one read until it hits, answering fetches after ack_delay extra FETCH cycles.
    task automatic do_read(input string tag, input logic [31:0] addr, input int ack_delay,
                           input bit flush_in_fetch, input int exp_stall, input int exp_req);
        int          stalls;
        int          reqs;
        int          burst;
        int          cyc;
        bit          done;
        bit          fired;
        logic [31:0] base;
        stalls = 0; reqs = 0; burst = 0; cyc = 0; done = 1'b0; fired = 1'b0;
        base = {addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        exp_q.push_back(mem_word(addr));
        while (!done && cyc < 64) begin
            @(negedge clk);
            ren = 1'b1; raddr = addr; mem_ack = 1'b0; flush = 1'b0;
            #1;
            cyc++;
            if (hit) begin
                check({tag, "_rdata"}, rdata, exp_q.pop_front());
                check({tag, "_stall_on_hit"}, 32'(stall), 32'd0);
                check({tag, "_req_on_hit"}, 32'(mem_req), 32'd0);
                done = 1'b1;
            end else begin
                stalls++;
                check({tag, "_stall"}, 32'(stall), 32'd1);
                check({tag, "_rdata_zero"}, rdata, 32'd0);
                if (mem_req) begin
                    reqs++;
                    burst++;
                    check({tag, "_mem_addr"}, mem_addr, base);
                    if (flush_in_fetch && !fired) begin
                        flush = 1'b1;
                        fired = 1'b1;
                    end
                    if (burst > ack_delay) begin
                        mem_ack   = 1'b1;
                        mem_block = mem_blk(base);
                    end
                end else begin
                    burst = 0;
                end
            end
        end
        check({tag, "_done"}, 32'(done), 32'd1);
        if (!done) exp_q.delete();
        check({tag, "_stall_cycles"}, 32'(stalls), 32'(exp_stall));
        check({tag, "_req_cycles"}, 32'(reqs), 32'(exp_req));
    endtask

    task automatic model_read(input logic [31:0] a, input int d);
        logic [IDX_W-1:0] idx;
        logic [31:0]      tg;
        idx = a[2+OFF_W +: IDX_W];
        tg  = a >> (2 + OFF_W + IDX_W);
        if (m_valid[idx] && m_tag[idx] == tg) begin
            do_read("rand_hit", a, d, 1'b0, 0, 0);
        end else begin
            do_read("rand_miss", a, d, 1'b0, 3 + d, d + 1);
            m_valid[idx] = 1'b1;
            m_tag[idx]   = tg;
        end
    endtask

    initial begin
        bit got;
        // reset state, with a read request pending
        rst = 1'b1; ren = 1'b1; raddr = 32'h100;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check("rst_hit", 32'(hit), 32'd0);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_state", 32'(dbg_state), 32'd0);
`ifdef ICACHE_STATS_EN
        check("rst_hit_cnt", hit_cnt, 32'd0);
        check("rst_miss_cnt", miss_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0; ren = 1'b0;

        do_read("cold", 32'h100, 0, 1'b0, 3, 1);
        do_read("spatial", 32'h10C, 0, 1'b0, 0, 0);
        @(negedge clk);
        ren = 1'b0; #1;
`ifdef ICACHE_STATS_EN
        check("stats_miss_cnt", miss_cnt, 32'd1);
        check("stats_hit_cnt", hit_cnt, 32'd2);
`endif

        do_read("conflict_fill", 32'h200, 5, 1'b0, 8, 6);
        do_read("conflict_evicted", 32'h100, 0, 1'b0, 3, 1);

        do_read("flush_in_fetch", 32'h300, 0, 1'b1, 7, 2);

        // flush in IDLE beats a hit on a valid line and starts no fetch
        @(negedge clk);
        ren = 1'b1; raddr = 32'h300; flush = 1'b1; #1;
        check("flush_idle_hit", 32'(hit), 32'd0);
        check("flush_idle_stall", 32'(stall), 32'd1);
        @(negedge clk);
        ren = 1'b0; flush = 1'b0; #1;
        check("flush_idle_no_req", 32'(mem_req), 32'd0);
        do_read("after_flush", 32'h300, 2, 1'b0, 5, 3);

        // reset while fetching, then a late ack that must be ignored
        @(negedge clk);
        ren = 1'b1; raddr = 32'h100; #1;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clk); #1;
            if (mem_req) got = 1'b1;
        end
        check("rmm_req_seen", 32'(got), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; ren = 1'b0; mem_ack = 1'b1; mem_block = mem_blk(32'h100); #1;
        check("rmm_req_drop", 32'(mem_req), 32'd0);
        check("rmm_mem_addr", mem_addr, 32'd0);
        check("rmm_stall", 32'(stall), 32'd0);
        @(negedge clk);
        mem_ack = 1'b0; #1;
        check("rmm_late_ack_req", 32'(mem_req), 32'd0);
        do_read("rmm_refetch", 32'h100, 1, 1'b0, 4, 2);

        // random reads against the reference model, starting from an empty cache
        @(negedge clk);
        ren = 1'b0; flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        for (int i = 0; i < LINES; i++) m_valid[i] = 1'b0;
        for (int k = 0; k < 24; k++) begin
            logic [31:0] a;
            int          d;
            a = 32'($urandom_range(0, 32'h2FF));
            d = int'($urandom_range(0, 3));
            model_read(a, d);
        end

        @(negedge clk);
        ren = 1'b0;
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
